// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor: counter encoding and BTB entry layout.
// Entry fields are sized for the widest supported configuration; narrower builds zero-extend.
package bp_pkg;

    localparam int BP_XLEN_MAX  = 64;
    localparam int BP_TAG_W_MAX = 32;

    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_ctr_t;

    typedef struct packed {
        logic                    valid;
        logic [BP_TAG_W_MAX-1:0] tag;
        logic [BP_XLEN_MAX-1:0]  target;
        bp_ctr_t                 ctr;
    } bp_entry_t;

    localparam bp_ctr_t BP_CTR_RESET = BP_WNT;
    localparam bp_ctr_t BP_CTR_ALLOC = BP_WT;

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state logic for one 2-bit saturating taken/not-taken counter.
module bp_sat_ctr
    import bp_pkg::*;
(
    input  bp_ctr_t ctr,
    input  logic    taken,
    output bp_ctr_t ctr_next
);

    always_comb begin
        ctr_next = ctr;
        unique case (ctr)
            BP_SNT:  ctr_next = taken ? BP_WNT : BP_SNT;
            BP_WNT:  ctr_next = taken ? BP_WT  : BP_SNT;
            BP_WT:   ctr_next = taken ? BP_ST  : BP_WNT;
            BP_ST:   ctr_next = taken ? BP_ST  : BP_WT;
            default: ctr_next = ctr;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; zero-latency lookup, registered update from ID.
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8
) (
    input  logic            clk_div,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_if,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic            hit,
    input  logic            clear,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken
`ifdef BP_STATS_EN
    ,
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_updates,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);

    bp_entry_t        entry_q [ENTRIES];
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [TAG_W-1:0] up_tag;
    bp_entry_t        lk_entry;
    bp_ctr_t          up_ctr;
    bp_ctr_t          ctr_next;
    logic             up_hit;

    assign lk_idx   = pc_if[IDX_W+1:2];
    assign lk_tag   = pc_if[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx   = upd_pc[IDX_W+1:2];
    assign up_tag   = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Lookup reads the registered table only, so a same-cycle update is not visible yet.
    assign lk_entry    = entry_q[lk_idx];
    assign hit         = lk_entry.valid && (lk_entry.tag == BP_TAG_W_MAX'(lk_tag));
    assign pred_taken  = hit && lk_entry.ctr[1];
    assign pred_target = hit ? lk_entry.target[XLEN-1:0] : '0;

    assign up_ctr = entry_q[up_idx].ctr;
    assign up_hit = entry_q[up_idx].valid && (entry_q[up_idx].tag == BP_TAG_W_MAX'(up_tag));

    bp_sat_ctr u_sat_ctr (
        .ctr      (up_ctr),
        .taken    (upd_taken),
        .ctr_next (ctr_next)
    );

    always_ff @(posedge clk_div or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: BP_CTR_RESET};
            end
        end else if (clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_q[i].valid <= 1'b0;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                entry_q[up_idx].ctr <= ctr_next;
                if (upd_taken) begin
                    entry_q[up_idx].target <= BP_XLEN_MAX'(upd_target);
                end
            end else if (upd_taken) begin
                // A taken miss evicts whatever branch currently owns this index.
                entry_q[up_idx] <= '{valid:  1'b1,
                                     tag:    BP_TAG_W_MAX'(up_tag),
                                     target: BP_XLEN_MAX'(upd_target),
                                     ctr:    BP_CTR_ALLOC};
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk_div or negedge rst) begin
        if (!rst) begin
            stat_lookups     <= '0;
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (hit && (stat_lookups != 32'hFFFF_FFFF)) begin
                stat_lookups <= stat_lookups + 32'd1;
            end
            if (upd_valid && (stat_updates != 32'hFFFF_FFFF)) begin
                stat_updates <= stat_updates + 32'd1;
            end
            if (upd_valid && (upd_pred_taken != upd_taken) &&
                (stat_mispredicts != 32'hFFFF_FFFF)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

    // Alignment bits and PC bits above the tag field carry no information here.
    logic unused_bits;
`ifdef BP_STATS_EN
    assign unused_bits = ^{pc_if[1:0], upd_pc[1:0],
                           pc_if[XLEN-1:IDX_W+TAG_W+2], upd_pc[XLEN-1:IDX_W+TAG_W+2]};
`else
    assign unused_bits = ^{pc_if[1:0], upd_pc[1:0], upd_pred_taken,
                           pc_if[XLEN-1:IDX_W+TAG_W+2], upd_pc[XLEN-1:IDX_W+TAG_W+2]};
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch prediction unit for the IF stage of the 5-stage 64-bit core.
- Replaces the resolve-in-ID, predict-not-taken scheme. Combines a direct-mapped branch target buffer (BTB) with a 2-bit saturating-counter history table.
- IF looks it up with the current PC every cycle.
- ID sends an update after each conditional branch resolves.
- The fetch mux selects pred_target when pred_taken is high.

Parameters:
- XLEN, 64, width of PC and target addresses.
- ENTRIES, 16, number of BTB/counter entries; power of two, 2..256.
- TAG_W, 8, number of PC bits stored as tag above the index field.
- IDX_W, $clog2(ENTRIES), derived local parameter; not overridable.

Ports:
- clk_div  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- pc_if  input  XLEN  fetch PC, byte address, 4-byte aligned.
- pred_taken  output  1  predict taken for pc_if.
- pred_target  output  XLEN  predicted target; 0 when hit is low.
- hit  output  1  valid entry with matching tag for pc_if.
- clear  input  1  synchronous invalidate of all entries (fence.i / context change).
- upd_valid  input  1  a conditional branch resolved in ID this cycle.
- upd_pc  input  XLEN  PC of the resolved branch.
- upd_taken  input  1  actual outcome.
- upd_target  input  XLEN  actual taken target.
- upd_pred_taken  input  1  prediction issued for that branch; used only for statistics.

Behaviour:
- Address fields:
  - index = pc[IDX_W+1:2]
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2]
  - pc[1:0] ignored.
- Per-entry state: valid (1), tag (TAG_W), target (XLEN), ctr (2 bits).
  - ctr encoding: 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
- Lookup is combinational, zero latency:
  - hit = valid[index] && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = hit ? target : 0.
- Update is registered; new state is visible to lookups from the next cycle.
  - Update hit, upd_taken=1: ctr saturating increment (11 stays 11); target overwritten with upd_target.
  - Update hit, upd_taken=0: ctr saturating decrement (00 stays 00); target unchanged.
  - Update miss, upd_taken=1: allocate the entry, overwriting any other tag. Set valid=1, tag, target, ctr=10.
  - Update miss, upd_taken=0: no change; no allocation.
- Simultaneous lookup and update to the same index: lookup returns the pre-update contents. No write-to-read bypass.
- clear and upd_valid in the same cycle: clear wins; all valid bits become 0 and the update is dropped.
- Reset (rst low, asynchronous):
  - All valid bits 0; all ctr 01; tags and targets 0.
  - Outputs hit=0, pred_taken=0, pred_target=0 for any pc_if while reset is held and afterwards until the first update.
  - Reset mid-update discards the update.
- Unaligned upd_pc (bits [1:0] nonzero) is a protocol violation. Index and tag still use the defined bits; no error is raised.

Optional Feature:
- Macro BP_STATS_EN.
- Defined: adds outputs stat_lookups, stat_updates and stat_mispredicts, each 32 bits.
  - stat_lookups increments each cycle hit=1.
  - stat_updates increments on each upd_valid.
  - stat_mispredicts increments when upd_valid && (upd_pred_taken != upd_taken).
  - All three saturate at 32'hFFFF_FFFF.
  - All three reset to 0 on rst; clear does not affect them.
- Undefined: the ports and counters do not exist; upd_pred_taken is unused.

Decomposition:
- Package bp_pkg holds:
  - Typedef bp_ctr_t: enum of the four counter states with the encodings above.
  - Typedef bp_entry_t: packed struct {valid, tag, target, ctr}.
  - Constants BP_CTR_RESET=01 and BP_CTR_ALLOC=10.
- Sub-module bp_sat_ctr: combinational next-state for one 2-bit counter.
  - Inputs: bp_ctr_t current value, 1-bit taken.
  - Output: bp_ctr_t next value.
  - Instantiated once on the update path.

Test Plan:
- Reset then lookup pc_if=0x100 -> hit=0, pred_taken=0, pred_target=0.
- Update upd_pc=0x100, taken=1, target=0x40; next cycle lookup 0x100 -> hit=1, pred_taken=1, pred_target=0x40, ctr=10.
- Two not-taken updates on 0x100 -> ctr 10→01→00, pred_taken=0, hit=1. Five taken updates -> ctr saturates at 11, stays 11.
- Aliasing, ENTRIES=16:
  - Taken update 0x100 (index 0), then taken update 0x140 target 0x80 (index 0, different tag).
  - Lookup 0x100 -> hit=0; lookup 0x140 -> hit=1, target 0x80.
- Same-cycle lookup and update on 0x100 (ctr 10, update not-taken) -> that cycle pred_taken=1; next cycle pred_taken=0.
- clear with upd_valid=1 in the same cycle -> next cycle every lookup hit=0.
- With BP_STATS_EN: 3 updates with one mismatch -> stat_updates=3, stat_mispredicts=1.
- Async rst pulse mid-sequence -> all state and counters return to reset values immediately.
